// File: rtl/seq_restoring_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_restoring_divider_pkg
//  Purpose  : Shared FSM state encoding and default operand width for the
//             iterative restoring divider.
//  Revision : 1.0  initial release
// ============================================================================
package seq_restoring_divider_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : seq_restoring_divider_pkg
`default_nettype wire

// File: rtl/seq_restoring_divider_fullsub.sv
`default_nettype none
// ============================================================================
//  Module   : fullsub
//  Purpose  : One-bit full subtractor cell (a - b - bin), the dual of a full
//             adder; chained to form the divider's trial-subtract path.
//  Revision : 1.0  initial release
// ============================================================================
module fullsub (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : fullsub
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_restoring_divider
//  Purpose  : Unsigned restoring divider, one quotient bit per clock, with a
//             start/done handshake and divide-by-zero flag.
//  Revision : 1.0  initial release
// ============================================================================
module seq_restoring_divider
   import seq_restoring_divider_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [WIDTH-1:0]   d_q,     d_d;      // latched divisor
   logic [WIDTH-1:0]   r_q,     r_d;      // partial remainder
   logic [WIDTH-1:0]   q_q,     q_d;      // dividend shifting out / quotient shifting in
   logic [WIDTH-1:0]   quo_q,   quo_d;
   logic [WIDTH-1:0]   rem_q,   rem_d;
   logic               dbz_q,   dbz_d;

   // Trial subtract is WIDTH+1 bits wide: the shifted remainder can reach 2*D-1.
   logic [WIDTH:0]     sub_a;
   logic [WIDTH:0]     sub_b;
   logic [WIDTH:0]     sub_diff;
   logic [WIDTH+1:0]   sub_borrow;
   logic               sub_fit;
   logic [WIDTH-1:0]   r_next;
   logic [WIDTH-1:0]   q_next;

   assign sub_a         = {r_q, q_q[WIDTH-1]};
   assign sub_b         = {1'b0, d_q};
   assign sub_borrow[0] = 1'b0;

   for (genvar i = 0; i <= WIDTH; i++) begin : g_sub_chain
      fullsub u_fullsub (
         .a    (sub_a[i]),
         .b    (sub_b[i]),
         .bin  (sub_borrow[i]),
         .diff (sub_diff[i]),
         .bout (sub_borrow[i+1])
      );
   end

   // The difference is kept only if no borrow left the chain; the top diff
   // bit is necessarily 0 in that case, so folding it in is purely defensive.
   assign sub_fit = ~sub_borrow[WIDTH+1] & ~sub_diff[WIDTH];
   assign r_next  = sub_fit ? sub_diff[WIDTH-1:0] : sub_a[WIDTH-1:0];
   assign q_next  = {q_q[WIDTH-2:0], sub_fit};

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         d_q     <= '0;
         r_q     <= '0;
         q_q     <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         d_q     <= d_d;
         r_q     <= r_d;
         q_q     <= q_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   // Next-state and datapath update; results only change when entering DONE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      d_d     = d_q;
      r_d     = r_q;
      q_d     = q_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (divisor != '0) begin
                  d_d     = divisor;
                  q_d     = dividend;
                  r_d     = '0;
                  cnt_d   = '0;
                  dbz_d   = 1'b0;
                  state_d = ST_RUN;
               end else begin
                  // Divide by zero skips iteration and reports straight away.
                  quo_d   = '1;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            r_d   = r_next;
            q_d   = q_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               quo_d   = q_next;
               rem_d   = r_next;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule : seq_restoring_divider
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_restoring_divider
//  Purpose  : Directed self-checking bench for seq_restoring_divider (WIDTH=8)
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_restoring_divider;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   seq_restoring_divider #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running edge counter used to measure done-to-done spacing.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One operation with start pulsed for a single cycle. lat is the number of
   // edges after the accepting edge until done is seen (8 normal, 0 for /0).
   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input int exp_lat, input logic [7:0] eq, input logic [7:0] er,
                         input logic edbz);
      int n;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      step();
      start = 1'b0;
      chk({tag, "_busy_accept"}, 32'(busy), 32'd1);
      n = 0;
      while (!done && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_latency"}, n, exp_lat);
      chk({tag, "_quotient"}, 32'(quotient), 32'(eq));
      chk({tag, "_remainder"}, 32'(remainder), 32'(er));
      chk({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
      step();
      chk({tag, "_done_width"}, 32'(done), 32'd0);
      chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [7:0] a, b, ea, eb;
      int         n, t_prev, seen;

      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_quotient", 32'(quotient), 32'd0);
      chk("rst_remainder", 32'(remainder), 32'd0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);
      rst = 1'b0;
      step();

      // Directed vectors, hand-computed.
      run_op("d100_7",   8'd100, 8'd7,   8, 8'd14,  8'd2,   1'b0);
      run_op("d255_1",   8'd255, 8'd1,   8, 8'd255, 8'd0,   1'b0);
      run_op("d5_9",     8'd5,   8'd9,   8, 8'd0,   8'd5,   1'b0);
      run_op("d0_3",     8'd0,   8'd3,   8, 8'd0,   8'd0,   1'b0);
      run_op("d255_255", 8'd255, 8'd255, 8, 8'd1,   8'd0,   1'b0);
      run_op("d200_0",   8'd200, 8'd0,   0, 8'hFF,  8'd200, 1'b1);

      // Flag stays set until the next accepted start, then clears there.
      dividend = 8'd10;
      divisor  = 8'd3;
      start    = 1'b1;
      step();
      start = 1'b0;
      chk("dbz_clear_on_start", 32'(div_by_zero), 32'd0);
      chk("held_quotient_during_run", 32'(quotient), 32'hFF);
      n = 0;
      while (!done && n < 20) begin
         step();
         n++;
      end
      chk("d10_3_latency", n, 8);
      chk("d10_3_quotient", 32'(quotient), 32'd3);
      chk("d10_3_remainder", 32'(remainder), 32'd1);
      step();

      // start re-pulsed mid-RUN with new operands must be ignored.
      dividend = 8'd100;
      divisor  = 8'd7;
      start    = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      dividend = 8'd50;
      divisor  = 8'd3;
      start    = 1'b1;
      step();
      start = 1'b0;
      chk("ignore_busy", 32'(busy), 32'd1);
      n = 3;
      while (!done && n < 20) begin
         step();
         n++;
      end
      chk("ignore_latency", n, 8);
      chk("ignore_quotient", 32'(quotient), 32'd14);
      chk("ignore_remainder", 32'(remainder), 32'd2);
      step();
      chk("ignore_no_restart", 32'(busy), 32'd0);

      // Asynchronous reset partway through RUN (between edges 4 and 5).
      dividend = 8'd100;
      divisor  = 8'd7;
      start    = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      #2;
      rst = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_quotient", 32'(quotient), 32'd0);
      chk("abort_remainder", 32'(remainder), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      step();
      rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (done) seen = 1;
      end
      chk("abort_no_done", seen, 0);
      run_op("post_abort_255_255", 8'd255, 8'd255, 8, 8'd1, 8'd0, 1'b0);

      // Back-to-back random operations with start held high throughout.
      a        = 8'($urandom_range(255, 0));
      b        = 8'($urandom_range(255, 1));
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      step();
      t_prev = 0;
      for (int i = 0; i < 1000; i++) begin
         ea       = a;
         eb       = b;
         a        = 8'($urandom_range(255, 0));
         b        = 8'($urandom_range(255, 1));
         dividend = a;
         divisor  = b;
         n = 0;
         while (!done && n < 20) begin
            step();
            n++;
         end
         chk("b2b_latency", n, 8);
         if (i > 0) chk("b2b_spacing", cyc - t_prev, 10);
         t_prev = cyc;
         chk("b2b_quotient", 32'(quotient), 32'(ea / eb));
         chk("b2b_remainder", 32'(remainder), 32'(ea % eb));
         if (i == 999) start = 1'b0;
         step();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_seq_restoring_divider
`default_nettype wire
